instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Inst_Address  output  64  the fetch address driven to instruction memory.
REQ-005 SHALL have port Instruction  input  32  the instruction word returned by memory for Inst_Address in the same cycle (combinational read).
REQ-006 SHALL have port redirect_valid  input  1  taken branch/jump from execute.
REQ-007 SHALL have port redirect_target  input  64  new fetch address, valid with redirect_valid.
REQ-008 SHALL have port out_valid  output  1  a fetched instruction is offered to decode.
REQ-009 SHALL have port out_ready  input  1  decode accepts the offered instruction.
REQ-010 SHALL have port out_instr  output  32  offered instruction word.
REQ-011 SHALL have port out_pc  output  64  address of out_instr.
REQ-012 SHALL have port misalign_err  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-013 SHALL hold a fetch_pc register; Inst_Address SHALL equal fetch_pc combinationally.
REQ-014 SHALL buffer fetched {pc, instruction} pairs in a 2-entry FIFO with states EMPTY, ONE, FULL (entry count 0/1/2).
REQ-015 Pop: SHALL occur when out_valid && out_ready; head entry removed at the clock edge.
REQ-016 Push: SHALL occur when no redirect, no misalign halt, and (state != FULL or pop this cycle); pushes {fetch_pc, Instruction} and fetch_pc <= fetch_pc + 4.
REQ-017 Without push, fetch_pc SHALL hold its value.
REQ-018 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop without push; push+pop SHALL leave state unchanged.
REQ-019 out_valid SHALL be (state != EMPTY) && !redirect_valid; out_instr/out_pc SHALL be the head entry.
REQ-020 Redirect SHALL have priority: FIFO flushed to EMPTY, fetch_pc <= target, no push, any pop that cycle discarded.
REQ-021 Latency: instruction at fetch address A SHALL appear on out_valid one cycle after fetch_pc = A and a push occurs; after redirect in cycle N, target instruction SHALL be offered in cycle N+2.
REQ-022 fetch_pc + 4 SHALL wrap modulo 2^64.
REQ-023 out_instr/out_pc SHALL remain stable while out_valid && !out_ready.

Reset
REQ-024 reset SHALL set fetch_pc = RESET_PC, state = EMPTY, misalign_err = 0, FIFO contents = 0.
REQ-025 Output reset values: out_valid 0, out_instr 32'h0, out_pc 64'h0, Inst_Address RESET_PC.
REQ-026 reset SHALL override redirect, push and pop in the same cycle, including mid-stream with FIFO FULL.

Configuration
REQ-027 Macro IFU_MISALIGN_CHECK_EN SHALL select redirect alignment handling.
REQ-028 Defined: redirect with target[1:0] != 0 SHALL flush FIFO, load fetch_pc = target, set misalign_err, and block pushes until reset or an aligned redirect (which clears misalign_err).
REQ-029 Undefined: target[1:0] SHALL be forced to 2'b00 on load; misalign_err SHALL be tied 0.

Verification
REQ-030 Reset then release, out_ready=1, memory holding the standard sort program -> cycle 1: out_pc 0x0, out_instr 0x10000593; cycle 2: out_pc 0x4, out_instr 0x01100093; one instruction per cycle thereafter.
REQ-031 out_ready=0 for 4 cycles after reset -> state FULL with pcs 0x0, 0x4; Inst_Address holds 0x8; out_pc stays 0x0; on out_ready=1, pcs 0x0, 0x4, 0x8 delivered on consecutive cycles.
REQ-032 FULL plus out_ready=1 steady -> simultaneous push/pop, state stays FULL, no pc skipped or duplicated.
REQ-033 Redirect to 0x30 while FULL with out_ready=1 -> out_valid 0 that cycle, 0 next cycle, then out_pc 0x30, out_instr 0x10000293; stale entries never offered.
REQ-034 With IFU_MISALIGN_CHECK_EN: redirect to 0x32 -> misalign_err 1, out_valid 0 until redirect to 0x40, then out_pc 0x40; without macro: redirect to 0x32 -> out_pc 0x30, misalign_err 0.
REQ-035 reset asserted for 1 cycle while FULL and redirect_valid=1 -> next cycle out_valid 0, Inst_Address RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential PC, redirect handling and a 2-entry {pc, instr} skid FIFO to decode.
// Optional macro IFU_MISALIGN_CHECK_EN: halt fetching on a misaligned redirect target instead of truncating it.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_fetch_pc, w_fetch_pc_nxt;
  logic        r_misalign, w_misalign_nxt;
  logic [63:0] r_pc0, r_pc1;
  logic [31:0] r_ins0, r_ins1;
  logic        w_push, w_pop, w_target_bad;
  logic [63:0] w_load_target;

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_target_bad  = (redirect_target[1:0] != 2'b00);
  assign w_load_target = redirect_target;
`else
  logic w_unused_lowbits;
  assign w_unused_lowbits = ^redirect_target[1:0];
  assign w_target_bad     = 1'b0;
  assign w_load_target    = {redirect_target[63:2], 2'b00};
`endif

  assign Inst_Address = r_fetch_pc;
  assign out_valid    = (r_state != EMPTY) && !redirect_valid;
  assign out_pc       = r_pc0;
  assign out_instr    = r_ins0;
  assign misalign_err = r_misalign;
  assign w_pop        = out_valid && out_ready;
  // A sticky misalign flag stops fetching until an aligned redirect or reset.
  assign w_push       = !redirect_valid && !r_misalign && ((r_state != FULL) || w_pop);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_misalign_nxt = r_misalign;
    if (redirect_valid) begin
      w_state_nxt    = EMPTY;
      w_fetch_pc_nxt = w_load_target;
      w_misalign_nxt = w_target_bad;
    end else begin
      if (w_push) w_fetch_pc_nxt = r_fetch_pc + 64'd4;
      case (r_state)
        EMPTY:   if (w_push) w_state_nxt = ONE;
        ONE:     if (w_push && !w_pop) w_state_nxt = FULL;
                 else if (w_pop && !w_push) w_state_nxt = EMPTY;
        FULL:    if (w_pop && !w_push) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_fetch_pc <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // FIFO storage: entry 0 is the head offered to decode, entry 1 the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc0  <= 64'h0;
      r_ins0 <= 32'h0;
      r_pc1  <= 64'h0;
      r_ins1 <= 32'h0;
    end else begin
      if (w_pop && (r_state == FULL)) begin
        r_pc0  <= r_pc1;
        r_ins0 <= r_ins1;
      end
      if (w_push) begin
        if ((r_state == EMPTY) || ((r_state == ONE) && w_pop)) begin
          r_pc0  <= r_fetch_pc;
          r_ins0 <= Instruction;
        end else begin
          r_pc1  <= r_fetch_pc;
          r_ins1 <= Instruction;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model, directed scenarios and random traffic.
module tb_instruction_fetch_unit;

  localparam logic [63:0] TB_RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .reset(reset), .Inst_Address(Inst_Address), .Instruction(Instruction),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h10000593;
      64'h4:   return 32'h01100093;
      64'h30:  return 32'h10000293;
      default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
    endcase
  endfunction

  assign Instruction = mem(Inst_Address);

  // Reference model: fetch PC, queue of fetched PCs, sticky error flag.
  logic [63:0] m_q[$];
  logic [63:0] m_pc;
  logic        m_err;
  bit          m_ok = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic rv, input logic [63:0] tgt, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_target = tgt; out_ready = rdy;
    @(negedge clk);
    if (m_ok) begin
      logic ev;
      ev = (m_q.size() > 0) && !rv;
      chk("out_valid", {63'h0, out_valid}, {63'h0, ev});
      chk("Inst_Address", Inst_Address, m_pc);
      chk("misalign_err", {63'h0, misalign_err}, {63'h0, m_err});
      if (ev) begin
        chk("out_pc", out_pc, m_q[0]);
        chk("out_instr", {32'h0, out_instr}, {32'h0, mem(m_q[0])});
      end
    end
  endtask

  task automatic advance();
    if (reset) begin
      m_q.delete(); m_pc = TB_RESET_PC; m_err = 1'b0; m_ok = 1;
    end else if (redirect_valid) begin
      m_q.delete();
`ifdef IFU_MISALIGN_CHECK_EN
      m_pc  = redirect_target;
      m_err = (redirect_target[1:0] != 2'b00);
`else
      m_pc  = redirect_target & ~64'h3;
`endif
    end else begin
      logic pop, push;
      pop  = (m_q.size() > 0) && out_ready;
      push = !m_err && ((m_q.size() < 2) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rst, input logic rv, input logic [63:0] tgt, input logic rdy);
    drive(rst, rv, tgt, rdy);
    advance();
  endtask

  initial begin
    // Straight-line fetch after reset
    cyc(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_instr", {32'h0, out_instr}, 64'h0);
    chk("rst_inst_addr", Inst_Address, TB_RESET_PC);
    advance();
    drive(0, 0, 0, 1);
    chk("c1_pc", out_pc, 64'h0);
    chk("c1_instr", {32'h0, out_instr}, 64'h10000593);
    advance();
    drive(0, 0, 0, 1);
    chk("c2_pc", out_pc, 64'h4);
    chk("c2_instr", {32'h0, out_instr}, 64'h01100093);
    advance();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

    // Back-pressure fills the FIFO, then drains in order
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("full_inst_addr", Inst_Address, 64'h8);
    chk("full_out_pc", out_pc, 64'h0);
    advance();
    drive(0, 0, 0, 1);
    chk("drain_pc4", out_pc, 64'h4);
    advance();
    drive(0, 0, 0, 1);
    chk("drain_pc8", out_pc, 64'h8);
    advance();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Redirect while FULL with decode accepting
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    drive(0, 1, 64'h30, 1);
    chk("redir_valid_n", {63'h0, out_valid}, 64'h0);
    advance();
    drive(0, 0, 0, 1);
    chk("redir_valid_n1", {63'h0, out_valid}, 64'h0);
    advance();
    drive(0, 0, 0, 1);
    chk("redir_valid_n2", {63'h0, out_valid}, 64'h1);
    chk("redir_pc", out_pc, 64'h30);
    chk("redir_instr", {32'h0, out_instr}, 64'h10000293);
    advance();

    // Misaligned redirect
    cyc(0, 1, 64'h32, 1);
    cyc(0, 0, 0, 1);
`ifdef IFU_MISALIGN_CHECK_EN
    drive(0, 0, 0, 1);
    chk("mis_err", {63'h0, misalign_err}, 64'h1);
    chk("mis_halt", {63'h0, out_valid}, 64'h0);
    advance();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 64'h40, 1);
    cyc(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("mis_clear", {63'h0, misalign_err}, 64'h0);
    chk("mis_pc40", out_pc, 64'h40);
    advance();
`else
    drive(0, 0, 0, 1);
    chk("mis_err", {63'h0, misalign_err}, 64'h0);
    chk("mis_pc30", out_pc, 64'h30);
    advance();
`endif

    // Reset overrides a redirect while FULL
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 64'h100, 0);
    drive(0, 0, 0, 1);
    chk("rst_ovr_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_ovr_addr", Inst_Address, TB_RESET_PC);
    advance();

    // Wrap of the fetch address at the top of the address space
    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("wrap_addr", Inst_Address, 64'h0);
    advance();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic rst, rv, rdy;
      logic [63:0] tgt;
      rst = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = {52'h0, 12'($urandom_range(0, 4095))};
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 19) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, 4'($urandom_range(0, 15))};
      cyc(rst, rv, tgt, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
